ahb_sram_subordinate: RTL

//  AHB-Lite subordinate (responder) fronting an on-chip word-organised SRAM. Accepts single

---
 rtl/ahb_sram_subordinate.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised on-chip SRAM. It inserts a fixed number
// of wait states per OKAY transfer and gives a two-cycle ERROR for bad accesses.
module ahb_sram_subordinate #(
   parameter int          ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [2:0]  hburst,
   input  logic [1:0]  hsize,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic [31:0] hrdata,
   output logic        hresp
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   logic [1:0]            state_reg, state_next;
   logic [3:0]            wait_cnt_reg, wait_cnt_next;
   logic                  dp_valid_reg, dp_valid_next;
   logic [ADDR_WIDTH-1:0] word_reg, word_next;
   logic [1:0]            offs_reg, offs_next;
   logic [1:0]            size_reg, size_next;
   logic                  write_reg, write_next;

   logic        accept;
   logic        addr_err;
   logic        dp_done;
   logic        mem_we;
   logic [3:0]  byte_en;
   logic [31:0] rd_word;
   logic        unused_sig;

   // Burst type and the SEQ/NONSEQ distinction do not matter for single transfers.
   assign unused_sig = ^{hburst, htrans[0]};

   assign hreadyout = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
   assign hresp     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

   assign accept = hsel & hready & htrans[1] & hreadyout;

   // An OKAY data phase completes in the cycle it is pending while the FSM sits in IDLE.
   assign dp_done = (state_reg == ST_IDLE) & dp_valid_reg;
   assign mem_we  = dp_done & write_reg & ~rst;

   always_comb begin
      addr_err = 1'b0;
      if (hsize == 2'b11)
         addr_err = 1'b1;
      if ((hsize == 2'b01) && haddr[0])
         addr_err = 1'b1;
      if ((hsize == 2'b10) && (haddr[1:0] != 2'b00))
         addr_err = 1'b1;
      if (haddr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2])
         addr_err = 1'b1;
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      dp_valid_next = dp_valid_reg;
      word_next     = word_reg;
      offs_next     = offs_reg;
      size_next     = size_reg;
      write_next    = write_reg;
      case (state_reg)
         ST_IDLE, ST_ERR2: begin
            state_next    = ST_IDLE;
            dp_valid_next = 1'b0;
            if (accept) begin
               word_next  = haddr[ADDR_WIDTH+1:2];
               offs_next  = haddr[1:0];
               size_next  = hsize;
               write_next = hwrite;
               if (addr_err) begin
                  state_next = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_next    = ST_WAIT;
                  wait_cnt_next = WAIT_INIT;
                  dp_valid_next = 1'b1;
               end else begin
                  dp_valid_next = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            wait_cnt_next = wait_cnt_reg - 4'd1;
            if (wait_cnt_reg <= 4'd1)
               state_next = ST_IDLE;
         end
         ST_ERR1: begin
            state_next = ST_ERR2;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 4'd0;
         dp_valid_reg <= 1'b0;
         word_reg     <= '0;
         offs_reg     <= 2'b00;
         size_reg     <= 2'b00;
         write_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         dp_valid_reg <= dp_valid_next;
         word_reg     <= word_next;
         offs_reg     <= offs_next;
         size_reg     <= size_next;
         write_reg    <= write_next;
      end
   end

   // Little-endian lanes: lane n carries bits [8n+7:8n].
   always_comb begin
      byte_en = 4'b0000;
      case (size_reg)
         2'b00:   byte_en = 4'b0001 << offs_reg;
         2'b01:   byte_en = offs_reg[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   // One byte-wide array per lane keeps each write enable private to its own memory.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         always_ff @(posedge clk) begin
            if (mem_we && byte_en[gi])
               lane_mem[word_reg] <= hwdata[8*gi +: 8];
         end

         assign rd_word[8*gi +: 8] = lane_mem[word_reg];
      end
   endgenerate

   assign hrdata = (dp_done && !write_reg) ? rd_word : 32'h0000_0000;

endmodule
